// File: rtl/trade_z_engine_pkg.sv
// Shared types and default widths for the Z-score trade engine.
package trade_z_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQRT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int FRAC_W_DEF = 8;
    localparam int CH_W_DEF   = 2;

    function automatic int calc_z_w(input int data_w, input int frac_w);
        return data_w + frac_w;
    endfunction

endpackage

// File: rtl/trade_z_engine_seq_isqrt.sv
// Restoring bit-serial integer square root: one root bit per cycle.
// The radicand is captured on start; done pulses DATA_W cycles later with root valid.
module seq_isqrt #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   radicand,
    output logic                  done,
    output logic [DATA_W-1:0]     root
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] rad_q;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   root_q, root_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W+2:0]   rem_shift;
    logic [DATA_W+2:0]   trial;

    // The true remainder always fits DATA_W+1 bits, so the truncated subtract is exact.
    always_comb begin
        rem_shift = {rem_q, rad_q[2*DATA_W-1 -: 2]};
        trial     = {1'b0, root_q, 2'b01};
        if (rem_shift >= trial) begin
            rem_d  = rem_shift[DATA_W:0] - trial[DATA_W:0];
            root_d = {root_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_d  = rem_shift[DATA_W:0];
            root_d = {root_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rad_q  <= radicand;
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= CNT_W'(DATA_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rad_q  <= {rad_q[2*DATA_W-3:0], 2'b00};
                rem_q  <= rem_d;
                root_q <= root_d;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/trade_z_engine.sv
// Multi-channel Z-score engine: sequential sqrt then bit-serial divide, one tagged
// sample in flight, valid/ready on both sides, buy/sell against a runtime threshold.
module trade_z_engine
    import trade_z_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_ch,
    input  logic [DATA_W-1:0]         in_mean,
    input  logic [2*DATA_W-1:0]       in_sqr_mean,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [DATA_W+FRAC_W-1:0]  cfg_z_thresh,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH_W-1:0]           out_ch,
    output logic [DATA_W+FRAC_W-1:0]  out_z,
    output logic                      out_buy,
    output logic                      out_sell
);
    localparam int Z_W   = calc_z_w(DATA_W, FRAC_W);
    localparam int CNT_W = $clog2(Z_W + 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [Z_W-1:0]      thresh_q, thresh_d;
    logic [DATA_W-1:0]   delta_q, delta_d;
    logic                lt_q, lt_d;
    logic                gt_q, gt_d;
    logic [DATA_W-1:0]   div_q, div_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [Z_W-1:0]      quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic [Z_W-1:0]      out_z_q, out_z_d;
    logic                out_buy_q, out_buy_d;
    logic                out_sell_q, out_sell_d;

    logic [2*DATA_W-1:0] mean_sq;
    logic [2*DATA_W-1:0] variance;
    logic [DATA_W-1:0]   delta_in;
    logic                start;
    logic                sqrt_done;
    logic [DATA_W-1:0]   sqrt_root;
    logic [DATA_W:0]     rem_shift;
    logic [Z_W-1:0]      quo_next;
    logic [Z_W-1:0]      z_fin;
    logic                fin;

    assign in_ready = (state_q == IDLE);
    assign start    = in_ready & in_valid;

    // A negative variance can only come from rounding upstream; treat it as flat.
    assign mean_sq  = {{DATA_W{1'b0}}, in_mean} * {{DATA_W{1'b0}}, in_mean};
    assign variance = (in_sqr_mean < mean_sq) ? '0 : in_sqr_mean - mean_sq;
    assign delta_in = (in_data > in_mean) ? in_data - in_mean : in_mean - in_data;

    seq_isqrt #(
        .DATA_W   (DATA_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .radicand (variance),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        thresh_d    = thresh_q;
        delta_d     = delta_q;
        lt_d        = lt_q;
        gt_d        = gt_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_z_d     = out_z_q;
        out_buy_d   = out_buy_q;
        out_sell_d  = out_sell_q;
        rem_shift   = {rem_q, quo_q[Z_W-1]};
        quo_next    = {quo_q[Z_W-2:0], 1'b0};
        z_fin       = '0;
        fin         = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SQRT;
                    ch_d     = in_ch;
                    thresh_d = cfg_z_thresh;
                    delta_d  = delta_in;
                    lt_d     = (in_data < in_mean);
                    gt_d     = (in_data > in_mean);
                end
            end
            SQRT: begin
                if (sqrt_done) begin
                    if (sqrt_root == '0) begin
                        fin = 1'b1;
                    end else begin
                        state_d = DIV;
                        div_d   = sqrt_root;
                        rem_d   = '0;
                        quo_d   = {delta_q, {FRAC_W{1'b0}}};
                        cnt_d   = CNT_W'(Z_W);
                    end
                end
            end
            DIV: begin
                // The quotient register doubles as the numerator shift register.
                if (rem_shift >= {1'b0, div_q}) begin
                    rem_d       = rem_shift[DATA_W-1:0] - div_q;
                    quo_next[0] = 1'b1;
                end else begin
                    rem_d = rem_shift[DATA_W-1:0];
                end
                quo_d = quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    fin   = 1'b1;
                    z_fin = quo_next;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_buy_d   = 1'b0;
                    out_sell_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_ch_d    = ch_q;
            out_z_d     = z_fin;
            out_buy_d   = (z_fin > thresh_q) & lt_q;
            out_sell_d  = (z_fin > thresh_q) & gt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            thresh_q    <= '0;
            delta_q     <= '0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_z_q     <= '0;
            out_buy_q   <= 1'b0;
            out_sell_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            thresh_q    <= thresh_d;
            delta_q     <= delta_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_z_q     <= out_z_d;
            out_buy_q   <= out_buy_d;
            out_sell_q  <= out_sell_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_z     = out_z_q;
    assign out_buy   = out_buy_q;
    assign out_sell  = out_sell_q;

endmodule

// File: tb/tb_trade_z_engine.sv
// Bench for trade_z_engine: directed transactions, a spec-level scoreboard checked
// every cycle, and literal expectations for each directed case.
`timescale 1ns/1ps
module tb_trade_z_engine;
    localparam int DATA_W = 8;
    localparam int FRAC_W = 8;
    localparam int CH_W   = 2;
    localparam int Z_W    = DATA_W + FRAC_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid;
    logic                in_ready;
    logic [CH_W-1:0]     in_ch;
    logic [DATA_W-1:0]   in_mean;
    logic [2*DATA_W-1:0] in_sqr_mean;
    logic [DATA_W-1:0]   in_data;
    logic [Z_W-1:0]      cfg_z_thresh;
    logic                out_valid;
    logic                out_ready;
    logic [CH_W-1:0]     out_ch;
    logic [Z_W-1:0]      out_z;
    logic                out_buy;
    logic                out_sell;

    trade_z_engine #(
        .DATA_W       (DATA_W),
        .FRAC_W       (FRAC_W),
        .CH_W         (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ch        (in_ch),
        .in_mean      (in_mean),
        .in_sqr_mean  (in_sqr_mean),
        .in_data      (in_data),
        .cfg_z_thresh (cfg_z_thresh),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_z        (out_z),
        .out_buy      (out_buy),
        .out_sell     (out_sell)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [Z_W-1:0]  z;
        logic            buy;
        logic            sell;
        logic [CH_W-1:0] ch;
        int              acc;
        int              gap;
    } exp_t;

    exp_t exp_q[$];
    bit   busy      = 1'b0;
    bit   head_seen = 1'b0;
    bit   after_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result straight from the arithmetic definition of the Z-score.
    function automatic exp_t predict(input logic [DATA_W-1:0] m, input logic [2*DATA_W-1:0] sq,
                                     input logic [DATA_W-1:0] d, input logic [Z_W-1:0] th,
                                     input logic [CH_W-1:0] ch, input int acc);
        exp_t e;
        int   var_i;
        int   sd;
        int   dl;
        int   zi;
        var_i = int'(sq) - int'(m) * int'(m);
        if (var_i < 0) var_i = 0;
        sd = 0;
        while ((sd + 1) * (sd + 1) <= var_i) sd++;
        dl = (d > m) ? int'(d) - int'(m) : int'(m) - int'(d);
        zi = (sd == 0) ? 0 : (dl * (1 << FRAC_W)) / sd;
        e.z    = zi[Z_W-1:0];
        e.buy  = (zi > int'(th)) && (d < m);
        e.sell = (zi > int'(th)) && (d > m);
        e.ch   = ch;
        e.acc  = acc;
        // First sampling point after edge k+L is one negedge past the accept negedge plus L.
        e.gap  = ((sd == 0) ? DATA_W + 1 : DATA_W + Z_W + 1) + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            busy      = 1'b0;
            head_seen = 1'b0;
            after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_buy", out_buy, 0);
                chk("rst_out_sell", out_sell, 0);
                chk("rst_out_z", out_z, 0);
                chk("rst_out_ch", out_ch, 0);
                after_rst = 1'b0;
            end
            chk("in_ready", in_ready, !busy);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    if (!head_seen) begin
                        chk("latency", cyc - exp_q[0].acc, exp_q[0].gap);
                        head_seen = 1'b1;
                    end
                    chk("out_z", out_z, exp_q[0].z);
                    chk("out_buy", out_buy, exp_q[0].buy);
                    chk("out_sell", out_sell, exp_q[0].sell);
                    chk("out_ch", out_ch, exp_q[0].ch);
                    chk("buy_sell_excl", out_buy & out_sell, 0);
                end
            end else begin
                chk("idle_buy_sell", out_buy | out_sell, 0);
            end
            if (in_valid && !busy) begin
                exp_q.push_back(predict(in_mean, in_sqr_mean, in_data, cfg_z_thresh, in_ch, cyc));
                busy = 1'b1;
            end else if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                head_seen = 1'b0;
                busy      = 1'b0;
            end
        end
    end

    task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] mean,
                        input logic [2*DATA_W-1:0] sqm, input logic [DATA_W-1:0] data);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_ch        = ch;
        in_mean      = mean;
        in_sqr_mean  = sqm;
        in_data      = data;
        cfg_z_thresh = 16'd256;
        in_valid     = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_ch        = CH_W'($urandom);
        in_mean      = DATA_W'($urandom);
        in_sqr_mean  = (2*DATA_W)'($urandom);
        in_data      = DATA_W'($urandom);
        cfg_z_thresh = Z_W'($urandom);
    endtask

    task automatic expect_result(input string name, input logic [Z_W-1:0] z, input logic buy,
                                 input logic sell, input logic [CH_W-1:0] ch, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
            return;
        end
        $display("txn %s: ch=%0d z=%0d buy=%0d sell=%0d", name, out_ch, out_z, out_buy, out_sell);
        chk({name, "_z"}, out_z, z);
        chk({name, "_buy"}, out_buy, buy);
        chk({name, "_sell"}, out_sell, sell);
        chk({name, "_ch"}, out_ch, ch);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
            chk({name, "_held_valid"}, out_valid, 1);
            chk({name, "_held_z"}, out_z, z);
            chk({name, "_held_sell"}, out_sell, sell);
            chk({name, "_held_ch"}, out_ch, ch);
            chk({name, "_held_in_ready"}, in_ready, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        in_ch        = '0;
        in_mean      = '0;
        in_sqr_mean  = '0;
        in_data      = '0;
        cfg_z_thresh = 16'd256;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send(2'd2, 8'd100, 16'd10100, 8'd130);
        expect_result("t1_sell", 16'd768, 1'b0, 1'b1, 2'd2, 0);

        send(2'd1, 8'd100, 16'd10100, 8'd85);
        expect_result("t2_buy", 16'd384, 1'b1, 1'b0, 2'd1, 0);
        send(2'd3, 8'd100, 16'd10100, 8'd105);
        expect_result("t2_small", 16'd128, 1'b0, 1'b0, 2'd3, 0);
        send(2'd0, 8'd100, 16'd10100, 8'd110);
        expect_result("t2_equal", 16'd256, 1'b0, 1'b0, 2'd0, 0);

        send(2'd0, 8'd100, 16'd10000, 8'd120);
        expect_result("t3_var0", 16'd0, 1'b0, 1'b0, 2'd0, 0);
        send(2'd1, 8'd100, 16'd9000, 8'd50);
        expect_result("t3_clamp", 16'd0, 1'b0, 1'b0, 2'd1, 0);
        send(2'd2, 8'd100, 16'd10100, 8'd100);
        expect_result("t3_flat", 16'd0, 1'b0, 1'b0, 2'd2, 0);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(2'd2, 8'd100, 16'd10100, 8'd130);
        fork
            send(2'd1, 8'd100, 16'd10100, 8'd85);
            expect_result("t4_stall", 16'd768, 1'b0, 1'b1, 2'd2, 5);
        join
        expect_result("t4_second", 16'd384, 1'b1, 1'b0, 2'd1, 0);

        send(2'd3, 8'd100, 16'd10100, 8'd130);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        send(2'd1, 8'd100, 16'd10100, 8'd85);
        expect_result("t5_after", 16'd384, 1'b1, 1'b0, 2'd1, 0);

        fork
            begin
                send(2'd0, 8'd100, 16'd10100, 8'd130);
                send(2'd3, 8'd100, 16'd10100, 8'd85);
            end
            begin
                expect_result("t6_first", 16'd768, 1'b0, 1'b1, 2'd0, 0);
                expect_result("t6_second", 16'd384, 1'b1, 1'b0, 2'd3, 0);
            end
        join

        repeat (3) @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
